// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_pkg;

  localparam int unsigned UART_DATA_W   = 8;
  localparam logic        UART_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} tx_state_e;

  function automatic logic even_parity(input logic [UART_DATA_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester handshake plus serial-line observation bundle for uart_tx_sched.
interface uart_tx_sched_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 utxd;
  logic                 busy;
  logic [IDX_W-1:0]     grant_id;

  modport master (
    output req_valid, req_data,
    input  req_ready, utxd, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, utxd, busy, grant_id
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               hit
);
  int unsigned j;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    j   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(ptr) + i) % NUM_REQ;
      if (!hit && req[j]) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART TX line among NUM_REQ byte requesters.
// Define UART_TX_SCHED_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input logic             clk,
  input logic             rst,
  uart_tx_sched_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned BIT_W = $clog2(UART_DATA_W);
  localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_W - 1);

  tx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic                   utxd_q, utxd_d;
  logic                   busy_q, busy_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
`ifdef UART_TX_SCHED_PARITY_EN
  logic                   par_q, par_d;
`endif

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   idx;
  logic               hit;
  logic               wrap;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (idx),
    .hit (hit)
  );

  // Gated by rst so no accept strobe is visible while reset is held.
  assign bus.req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign bus.utxd      = utxd_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;

  assign wrap = (baud_q == BAUD_MAX);

  always_comb begin
    state_d = state_q;
    baud_d  = wrap ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
`ifdef UART_TX_SCHED_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (hit) begin
          state_d = START;
          shreg_d = bus.req_data[UART_DATA_W*idx +: UART_DATA_W];
          grant_d = idx;
          ptr_d   = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
`ifdef UART_TX_SCHED_PARITY_EN
          par_d   = even_parity(bus.req_data[UART_DATA_W*idx +: UART_DATA_W]);
`endif
        end
      end
      START: begin
        if (wrap) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (wrap) begin
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_SCHED_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end
      end
`ifdef UART_TX_SCHED_PARITY_EN
      PARITY: if (wrap) state_d = STOP;
`endif
      STOP: if (wrap) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Line level tracks the state being entered so utxd/busy stay aligned.
    case (state_d)
      START:   utxd_d = 1'b0;
      DATA:    utxd_d = shreg_d[0];
`ifdef UART_TX_SCHED_PARITY_EN
      PARITY:  utxd_d = par_d;
`endif
      default: utxd_d = UART_IDLE_LVL;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      utxd_q  <= UART_IDLE_LVL;
      busy_q  <= 1'b0;
      grant_q <= '0;
      ptr_q   <= '0;
`ifdef UART_TX_SCHED_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      utxd_q  <= utxd_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
`ifdef UART_TX_SCHED_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed requests, UART line decoder as monitor.
module tb_uart_tx_sched;
  localparam int NUM_REQ = 4;
  localparam int CPB     = 16;
`ifdef UART_TX_SCHED_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;
  localparam int GAP   = FRAME + 1;

  logic clk = 1'b0;
  logic rst;

  uart_tx_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_sched #(.NUM_REQ(NUM_REQ), .CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int id;
    int data;
    int gap;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         reset_seen = 1'b0;
  logic [7:0] pend [NUM_REQ][16];
  int         hd [NUM_REQ] = '{default: 0};
  int         tl [NUM_REQ] = '{default: 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic enq(input int i, input int d);
    pend[i][tl[i] % 16] = 8'(d);
    tl[i]++;
  endtask

  task automatic expect_frame(input int id, input int d, input int gap);
    exp_t e;
    e.id = id; e.data = d; e.gap = gap;
    exp_q.push_back(e);
  endtask

  function automatic bit all_drained();
    for (int i = 0; i < NUM_REQ; i++) if (hd[i] != tl[i]) return 1'b0;
    return (exp_q.size() == 0) && !bus.busy;
  endfunction

  task automatic wait_idle();
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (all_drained()) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: timeout, pending frames %0d expected 0", exp_q.size());
  endtask

  task automatic wait_busy();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.busy) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_busy: timeout, busy %0d expected 1", bus.busy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Requester model: holds valid/data until accepted, then presents its next byte.
  initial begin
    logic [NUM_REQ-1:0] acc;
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      acc = rst ? '0 : (bus.req_valid & bus.req_ready);
      if (bus.req_ready != '0) begin
        chk("ready_onehot", int'($onehot(bus.req_ready)), 1);
        chk("ready_only_idle", int'(bus.busy), 0);
        chk("ready_needs_valid", int'((bus.req_ready & ~bus.req_valid) != '0), 0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) hd[i]++;
        bus.req_valid[i]        = (hd[i] != tl[i]);
        bus.req_data[8*i +: 8]  = pend[i][hd[i] % 16];
      end
    end
  end

  // Monitor: decode each frame from utxd mid-bit samples and score it.
  initial begin
    int          c;
    int          gid;
    int          st;
    int          last_start;
    logic [31:0] bits;
    exp_t        e;
    last_start = -1;
    forever begin
      @(negedge clk);
      if (!rst && bus.busy && bus.utxd == 1'b0) begin
        st   = cyc;
        c    = 0;
        bits = '0;
        gid  = 0;
        while (bus.busy === 1'b1 && c < 400) begin
          if (c % CPB == CPB / 2) bits[c / CPB] = bus.utxd;
          gid = int'(bus.grant_id);
          c++;
          @(negedge clk);
        end
        if (reset_seen) begin
          reset_seen = 1'b0;
          last_start = -1;
        end else if (exp_q.size() == 0) begin
          chk("unexpected_frame_queue_size", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("start_bit", int'(bits[0]), 0);
          chk("data_byte", int'(bits[8:1]), e.data);
`ifdef UART_TX_SCHED_PARITY_EN
          chk("parity_bit", int'(bits[9]), int'(^(8'(e.data))));
`endif
          chk("stop_bit", int'(bits[NBITS-1]), 1);
          chk("frame_len", c, FRAME);
          chk("grant_id", gid, e.id);
          if (e.gap >= 0) chk("start_gap", st - last_start, e.gap);
          last_start = st;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_utxd", int'(bus.utxd), 1);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_ready", int'(bus.req_ready), 0);
    chk("reset_grant", int'(bus.grant_id), 0);
    @(posedge clk);
    #2 rst = 1'b0;

`ifdef UART_TX_SCHED_PARITY_EN
    // 0x07 has three ones: parity bit 1, 176-cycle frame.
    enq(0, 8'h07);
    expect_frame(0, 8'h07, -1);
    wait_idle();
    do_reset();
`endif

    // Single byte on requester 1.
    enq(1, 8'hA5);
    expect_frame(1, 8'hA5, -1);
    wait_idle();
    chk("grant_hold_after_frame", int'(bus.grant_id), 1);
    chk("line_idle_after_frame", int'(bus.utxd), 1);

    // Fairness from pointer 0 with all requesters active.
    do_reset();
    enq(0, 8'h10); enq(1, 8'h11); enq(2, 8'h12); enq(3, 8'h13); enq(0, 8'h20);
    expect_frame(0, 8'h10, -1);
    expect_frame(1, 8'h11, GAP);
    expect_frame(2, 8'h12, GAP);
    expect_frame(3, 8'h13, GAP);
    expect_frame(0, 8'h20, GAP);
    wait_idle();

    // Wrap: serve req 2 (pointer -> 3), then req 3 before req 0.
    enq(2, 8'h5A);
    expect_frame(2, 8'h5A, -1);
    expect_frame(3, 8'h7E, GAP);
    expect_frame(0, 8'h81, GAP);
    wait_busy();
    repeat (40) @(negedge clk);
    enq(0, 8'h81);
    enq(3, 8'h7E);
    wait_idle();

    // Valid raised mid-frame must wait for IDLE.
    enq(1, 8'hC3);
    expect_frame(1, 8'hC3, -1);
    expect_frame(2, 8'h96, GAP);
    wait_busy();
    repeat (50) @(negedge clk);
    enq(2, 8'h96);
    repeat (3) @(negedge clk);
    chk("hold_ready2_while_busy", int'(bus.req_ready[2]), 0);
    chk("hold_valid2_raised", int'(bus.req_valid[2]), 1);
    wait_idle();

    // Reset during data bit 4 aborts the frame.
    enq(1, 8'hFF);
    wait_busy();
    repeat (5 * CPB + CPB / 2 - 1) @(negedge clk);
    reset_seen = 1'b1;
    rst = 1'b1;
    #1;
    chk("midreset_utxd", int'(bus.utxd), 1);
    chk("midreset_busy", int'(bus.busy), 0);
    enq(0, 8'h3C);
    repeat (2) @(negedge clk);
    chk("midreset_ready", int'(bus.req_ready), 0);
    expect_frame(0, 8'h3C, -1);
    @(posedge clk);
    #2 rst = 1'b0;
    wait_idle();
    chk("post_reset_grant", int'(bus.grant_id), 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmit line among NUM_REQ byte-stream requesters.
- Sequences the shared serializer: arbitrates, latches one byte, emits an 8N1 frame on utxd, then re-arbitrates.
- Sits between internal producers (debug/log, command response, etc.) and the DUT-side utxd pin that the UART agent monitors.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CLKS_PER_BIT, 16, clk cycles per UART bit period (>=4)
- CNT_W, $clog2(CLKS_PER_BIT), width of the baud counter

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester byte-valid
- req_data  input  NUM_REQ*8  per-requester byte; requester i uses bits [8*i+7:8*i]
- req_ready  output  NUM_REQ  one-hot accept strobe; transfer when valid&ready
- utxd  output  1  serial TX line, idle high
- busy  output  1  high while a frame is in flight (START..STOP)
- grant_id  output  $clog2(NUM_REQ)  index of the requester owning the current/last frame

Behaviour:
- Reset (async assert, sync-safe deassert not required inside block): utxd=1, busy=0, req_ready=0, grant_id=0, rr pointer=0, FSM=IDLE. Mid-frame reset aborts the frame; utxd returns high the same instant. No partial byte is resumed.
- FSM states: IDLE, START, DATA, STOP (PARITY when feature enabled).
- IDLE: combinationally selects the first req_valid bit searching from rr pointer upward with wrap. If a hit on index k: req_ready[k]=1 this cycle, the byte is latched into the shift register, grant_id<=k, rr pointer<=(k+1) mod NUM_REQ, next state START. With no hit, req_ready=0 and the block stays in IDLE.
- req_ready is combinational from IDLE state and req_valid. It is at most one-hot and never asserted outside IDLE.
- Requester rule: once valid is raised, data must be held and valid kept high until ready. The block does not check this rule.
- START: utxd=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. The bit index counts 0..7.
- STOP: utxd=1 for CLKS_PER_BIT cycles, then IDLE.
- utxd is driven from a register, so the start bit appears on the cycle after the accept cycle.
- Frame period is 10*CLKS_PER_BIT clk cycles plus 1 IDLE cycle. Back-to-back frames therefore have exactly 1 extra idle-high cycle between the stop bit and the next start bit.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs on wrap. The counter clears on entry to START.
- busy=1 in START/DATA/STOP/PARITY and 0 in IDLE. It is registered and aligned with utxd.
- Simultaneous requests: the lowest index at or above the pointer wins. A newly asserted valid during a frame waits for the next IDLE.
- A single active requester holding valid continuously gets consecutive frames with no starvation of others. Each requester is served at most once per NUM_REQ grants when all are active.

Optional Feature:
- Macro UART_TX_SCHED_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles. It drives the even-parity bit (XOR of the 8 data bits). Frame becomes 11 bits, and the period becomes 11*CLKS_PER_BIT+1.
- Undefined: the PARITY state and parity logic are absent. Frame is 8N1.

Decomposition:
- Package uart_pkg holds:
  - state enum tx_state_e (IDLE, START, DATA, STOP, PARITY)
  - localparams UART_DATA_W=8, UART_IDLE_LVL=1'b1
  - function even_parity(byte)
- Sub-module rr_arbiter (NUM_REQ): request vector plus pointer in, one-hot grant and index out, purely combinational. It is reused by other schedulers.
- The FSM, shift register and baud counter stay in uart_tx_sched.

Test Plan:
- Single byte: CLKS_PER_BIT=16, req_valid=4'b0010, data1=8'hA5.
  - req_ready[1] pulses 1 cycle, grant_id=1.
  - utxd shows 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles, 160 cycles total.
  - busy drops after the stop bit.
- Round-robin fairness: all 4 requesters hold valid with bytes 8'h10..8'h13, pointer=0.
  - Grants are 0,1,2,3,0.
  - Frame start bits are 161 cycles apart.
- Wrap: pointer=3 after serving req 2, with only req 0 and req 3 valid.
  - Req 3 is served first, then req 0.
- Hold during busy: req 2 raises valid in mid-frame.
  - req_ready[2] stays 0 until IDLE, then the frame starts the next cycle.
- Reset mid-frame: assert rst during DATA bit 4.
  - utxd=1, busy=0, req_ready=0 immediately.
  - After release, with req 0 valid (8'h3C), a clean frame is sent with grant_id=0.
- With UART_TX_SCHED_PARITY_EN, byte 8'h07:
  - Parity bit = 1, placed between bit 7 and stop.
  - Frame is 176 cycles.
